bound_interval_reducer: RTL and testbench
=========================================

# bound_interval_reducer

Streaming sequential reducer that folds a frame of activation-tagged signed bounds, one per cycle, into a single feasible interval [lower_bound, upper_bound] for one variable. It keeps a running maximum of active lower bounds and a running minimum of active upper bounds, and applies the same activation semantics as the combinational min/max comparator tree. It sits directly upstream of the sampling stage. It replaces the comparator tree wherever constraints arrive serially rather than in parallel. The result is presented through a valid/ready handshake.

## Interface
- NUMBER_SIZE, 4: width of signed bound values (two's complement)
- COUNT_SIZE, 4: width of the active-bound counter
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  a candidate bound is presented
- in_ready  output  1  block accepts a candidate this cycle
- in_bound  input  NUMBER_SIZE  signed candidate bound
- in_is_upper  input  1  1 = upper bound (min-reduced), 0 = lower bound (max-reduced)
- in_activation  input  1  1 = candidate participates; 0 = candidate is ignored but still consumed
- in_last  input  1  candidate is the final beat of the frame
- out_valid  output  1  interval result is held and valid
- out_ready  input  1  downstream consumes the result
- lower_bound  output  NUMBER_SIZE  max of active lower bounds; 0 if none
- lower_activation  output  1  at least one active lower bound in the frame
- upper_bound  output  NUMBER_SIZE  min of active upper bounds; 0 if none
- upper_activation  output  1  at least one active upper bound in the frame
- interval_empty  output  1  both activations set and lower_bound > upper_bound (signed)
- active_count  output  COUNT_SIZE  number of active beats in the frame, saturating at 2^COUNT_SIZE-1

## Operation
- Two states: COLLECT and HOLD. Reset enters COLLECT.
- Accept: in_valid & in_ready.
- COLLECT behaviour:
  - in_ready=1, out_valid=0.
  - On an accepted beat with in_activation=1 and in_is_upper=1: if upper_activation=0 or in_bound < upper_bound (signed), load upper_bound. Set upper_activation=1.
  - Lower bounds mirror this with in_bound > lower_bound.
  - Each active beat increments active_count; it saturates and never wraps.
  - Inactive beats change no accumulator.
  - An accepted beat with in_last=1 moves to HOLD after its own update is applied.
- HOLD behaviour:
  - in_ready=0, out_valid=1, and all result outputs are stable.
  - On out_ready=1: clear all accumulators, activations and count to 0, then return to COLLECT.
- interval_empty is combinational from the registered outputs and is meaningful only while out_valid=1.
- Equal bounds (lower==upper) are not empty.
- A frame with no active beats yields both activations 0, both bounds 0, interval_empty=0 and active_count 0.
- A single-beat frame (first beat also last) is legal.
- Signed compare is over full NUMBER_SIZE with no extension. Values pass through unmodified.

## Timing
- Reset (asynchronous assert): state=COLLECT, in_ready=1 after reset, out_valid=0. All bounds, activations and active_count are 0.
- Reset mid-frame or mid-HOLD discards the partial or held result.
- Latency: out_valid rises on the clock edge that accepts the in_last beat, i.e. it is visible the cycle after that beat is presented.
- Result hold is at least 1 cycle. The handshake cycle with out_ready=1 is the last cycle of out_valid.
- The next frame's first beat is accepted no earlier than the cycle after the out_ready handshake.
- Throughput: N-beat frame occupies N+1 cycles minimum.
- in_valid while in HOLD is not accepted; the upstream block must hold its beat.
- out_ready while in COLLECT is ignored.
- in_valid=0 cycles in COLLECT (bubbles) change nothing.

## Test plan
- Frame (lower,act,5)(upper,act,3)(lower,act,2)(upper,act,6,last), NUMBER_SIZE=4 -> lower=5, upper=3, both activations 1, interval_empty=1, active_count=4, out_valid the cycle after last.
- Frame (upper,act,-8)(upper,inactive,-8... then 7)(lower,act,-3,last) -> upper=-8 (inactive 7 ignored), lower=-3, empty=1, count=2. Repeat with the -8 beat inactive -> upper_activation=0, upper=0, empty=0.
- Frame of 3 inactive beats -> all results 0, activations 0, empty 0; hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0, extra in_valid beats not consumed.
- Frame with lower=4 and upper=4 plus bubbles between beats -> empty=0. Back-to-back frames: second frame first beat accepted the cycle after handshake, accumulators start clean.
- COUNT_SIZE=2, 5 active beats -> active_count=3 (saturated).
- Assert rst_n=0 mid-frame and separately in HOLD -> outputs 0, out_valid=0, in_ready=1 after release; a new frame reduces correctly.

Source files
------------

// File: rtl/bound_interval_reducer.sv
// Folds a frame of activation-tagged signed bounds into one feasible interval.
// Latency: result valid the cycle after the in_last beat is accepted.
// Backpressure: in_ready low while a result is held until out_ready consumes it.
module bound_interval_reducer #(
    parameter int NUMBER_SIZE = 4,
    parameter int COUNT_SIZE  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [NUMBER_SIZE-1:0] in_bound,
    input  logic                          in_is_upper,
    input  logic                          in_activation,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [NUMBER_SIZE-1:0] lower_bound,
    output logic                          lower_activation,
    output logic signed [NUMBER_SIZE-1:0] upper_bound,
    output logic                          upper_activation,
    output logic                          interval_empty,
    output logic [COUNT_SIZE-1:0]         active_count
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    typedef struct packed {
        logic [NUMBER_SIZE-1:0] lo;
        logic                   lo_act;
        logic [NUMBER_SIZE-1:0] up;
        logic                   up_act;
        logic [COUNT_SIZE-1:0]  cnt;
    } acc_t;

    state_t state_q, state_d;
    acc_t   acc_q, acc_d;
    logic   in_ready_q, in_ready_d;
    logic   out_valid_q, out_valid_d;
    logic   accept;
    logic   tighter_up, tighter_lo;

    assign accept = in_valid & in_ready_q;

    // An inactive accumulator takes any first bound regardless of its value.
    assign tighter_up = !acc_q.up_act || ($signed(in_bound) < $signed(acc_q.up));
    assign tighter_lo = !acc_q.lo_act || ($signed(in_bound) > $signed(acc_q.lo));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (in_activation) begin
                        if (in_is_upper) begin
                            if (tighter_up) begin
                                acc_d.up = in_bound;
                            end
                            acc_d.up_act = 1'b1;
                        end else begin
                            if (tighter_lo) begin
                                acc_d.lo = in_bound;
                            end
                            acc_d.lo_act = 1'b1;
                        end
                        if (acc_q.cnt != {COUNT_SIZE{1'b1}}) begin
                            acc_d.cnt = acc_q.cnt + 1'b1;
                        end
                    end
                    if (in_last) begin
                        state_d     = HOLD;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d       = '0;
                    state_d     = COLLECT;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                acc_d       = '0;
                state_d     = COLLECT;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready         = in_ready_q;
    assign out_valid        = out_valid_q;
    assign lower_bound      = acc_q.lo;
    assign lower_activation = acc_q.lo_act;
    assign upper_bound      = acc_q.up;
    assign upper_activation = acc_q.up_act;
    assign active_count     = acc_q.cnt;
    assign interval_empty   = acc_q.lo_act && acc_q.up_act &&
                              ($signed(acc_q.lo) > $signed(acc_q.up));

endmodule

// File: tb/tb_bound_interval_reducer.sv
// Directed-vector bench for bound_interval_reducer; a second instance with COUNT_SIZE=2 checks saturation.
module tb_bound_interval_reducer;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_is_upper, in_activation, in_last, out_ready;
    logic signed [3:0] in_bound;

    logic              in_ready, out_valid, lower_activation, upper_activation, interval_empty;
    logic signed [3:0] lower_bound, upper_bound;
    logic [3:0]        active_count;

    logic              s_in_ready, s_out_valid, s_lo_act, s_up_act, s_empty;
    logic signed [3:0] s_lo, s_up;
    logic [1:0]        s_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bound_interval_reducer #(.NUMBER_SIZE(4), .COUNT_SIZE(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_bound(in_bound),
        .in_is_upper(in_is_upper), .in_activation(in_activation), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .lower_bound(lower_bound), .lower_activation(lower_activation),
        .upper_bound(upper_bound), .upper_activation(upper_activation),
        .interval_empty(interval_empty), .active_count(active_count)
    );

    bound_interval_reducer #(.NUMBER_SIZE(4), .COUNT_SIZE(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_bound(in_bound),
        .in_is_upper(in_is_upper), .in_activation(in_activation), .in_last(in_last),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .lower_bound(s_lo), .lower_activation(s_lo_act),
        .upper_bound(s_up), .upper_activation(s_up_act),
        .interval_empty(s_empty), .active_count(s_count)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic chk_result(input string tag, input int lo, input int lo_act,
                              input int up, input int up_act, input int empty, input int cnt);
        chk({tag, ".out_valid"}, int'(out_valid), 1);
        chk({tag, ".in_ready"}, int'(in_ready), 0);
        chk({tag, ".lower"}, int'(lower_bound), lo);
        chk({tag, ".lower_act"}, int'(lower_activation), lo_act);
        chk({tag, ".upper"}, int'(upper_bound), up);
        chk({tag, ".upper_act"}, int'(upper_activation), up_act);
        chk({tag, ".empty"}, int'(interval_empty), empty);
        chk({tag, ".count"}, int'(active_count), cnt);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".out_valid"}, int'(out_valid), 0);
        chk({tag, ".in_ready"}, int'(in_ready), 1);
        chk({tag, ".lower"}, int'(lower_bound), 0);
        chk({tag, ".upper"}, int'(upper_bound), 0);
        chk({tag, ".acts"}, int'({lower_activation, upper_activation}), 0);
        chk({tag, ".count"}, int'(active_count), 0);
    endtask

    // Presents one beat from just after a rising edge and holds it until accepted.
    task automatic beat(input logic up, input logic act, input logic signed [3:0] b, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1; in_is_upper = up; in_activation = act; in_bound = b; in_last = last;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("beat_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".rel_out_valid"}, int'(out_valid), 0);
        chk({tag, ".rel_in_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_is_upper = 1'b0; in_activation = 1'b0;
        in_last = 1'b0; in_bound = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Crossing bounds give an empty interval.
        beat(1'b0, 1'b1, 4'sd5, 1'b0);
        beat(1'b1, 1'b1, 4'sd3, 1'b0);
        beat(1'b0, 1'b1, 4'sd2, 1'b0);
        beat(1'b1, 1'b1, 4'sd6, 1'b1);
        chk_result("f1", 5, 1, 3, 1, 1, 4);
        release_result("f1");

        beat(1'b1, 1'b1, -4'sd8, 1'b0);
        beat(1'b1, 1'b0, 4'sd7, 1'b0);
        beat(1'b0, 1'b1, -4'sd3, 1'b1);
        chk_result("f2", -3, 1, -8, 1, 1, 2);
        release_result("f2");

        beat(1'b1, 1'b0, -4'sd8, 1'b0);
        beat(1'b1, 1'b0, 4'sd7, 1'b0);
        beat(1'b0, 1'b1, -4'sd3, 1'b1);
        chk_result("f3", -3, 1, 0, 0, 0, 1);
        release_result("f3");

        // All-inactive frame, then a stalled beat waiting through the hold.
        beat(1'b0, 1'b0, 4'sd5, 1'b0);
        beat(1'b1, 1'b0, 4'sd1, 1'b0);
        beat(1'b0, 1'b0, -4'sd2, 1'b1);
        chk_result("f4", 0, 0, 0, 0, 0, 0);
        in_valid = 1'b1; in_is_upper = 1'b1; in_activation = 1'b1; in_bound = -4'sd1; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_result("f4_stall", 0, 0, 0, 0, 0, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("f4_handshake_out_valid", int'(out_valid), 0);
        chk("f4_handshake_count", int'(active_count), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        chk_result("f5", 0, 0, -1, 1, 0, 1);
        release_result("f5");

        // Equal bounds with bubbles; out_ready during collection is ignored.
        beat(1'b0, 1'b1, 4'sd4, 1'b0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("f6_bubble_out_valid", int'(out_valid), 0);
        chk("f6_bubble_in_ready", int'(in_ready), 1);
        beat(1'b1, 1'b1, 4'sd4, 1'b1);
        chk_result("f6", 4, 1, 4, 1, 0, 2);
        release_result("f6");

        beat(1'b0, 1'b1, 4'sd1, 1'b0);
        beat(1'b0, 1'b1, 4'sd2, 1'b0);
        beat(1'b0, 1'b1, -4'sd1, 1'b0);
        beat(1'b0, 1'b1, 4'sd3, 1'b0);
        beat(1'b1, 1'b1, 4'sd7, 1'b1);
        chk_result("f7", 3, 1, 7, 1, 0, 5);
        chk("f7_sat_count", int'(s_count), 3);
        chk("f7_sat_out_valid", int'(s_out_valid), 1);
        release_result("f7");

        // Reset mid-frame discards the partial result.
        beat(1'b0, 1'b1, 4'sd6, 1'b0);
        beat(1'b1, 1'b1, -4'sd2, 1'b0);
        rst_n = 1'b0;
        #2;
        chk_idle("rst_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        beat(1'b1, 1'b1, 4'sd5, 1'b0);
        beat(1'b0, 1'b1, 4'sd1, 1'b1);
        chk_result("f8", 1, 1, 5, 1, 0, 2);

        // Reset while holding a result.
        rst_n = 1'b0;
        #2;
        chk_idle("rst_hold");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        beat(1'b1, 1'b1, 4'sd2, 1'b1);
        chk_result("f9", 0, 0, 2, 1, 0, 1);
        release_result("f9");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
